fp_add_arbiter: RTL and testbench

Shares one floating-point adder between up to NUM_REQ requester engines (angle normalization, angle combination and similar sequencers), each of which drives a single-cycle start pulse with two operands. The block latches each request, grants the adder round-robin, issues one addition at a time, and returns the sum with a one-cycle ready pulse to the originating requester. It sits between the requester wrappers and the single adder instance in the top level.

---
 rtl/fp_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fp_add_arbiter.sv | 122 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder arbiter: operand width helper
// and the arbiter state encoding.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    function automatic int fp_width(input int exp_len, input int mantissa_len);
        return exp_len + mantissa_len + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending requester after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         pend,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (pend[idx]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters: latches start pulses,
// grants round-robin, issues one addition at a time and routes the sum back.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int NUM_REQ      = 4,
    localparam int W           = fp_width(EXP_LEN, MANTISSA_LEN),
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_start,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [W-1:0]         req_sum,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_overrun,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_start,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_ready,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    arb_state_t                  state;
    logic [NUM_REQ-1:0]          pend;
    logic [NUM_REQ-1:0][W-1:0]   cap_a;
    logic [NUM_REQ-1:0][W-1:0]   cap_b;
    logic [IW-1:0]               last_grant;
    logic [IW-1:0]               winner;
    logic                        win_vld;
    logic                        done;
    logic [NUM_REQ-1:0]          in_flight;
    logic [NUM_REQ-1:0]          accept;
    logic [NUM_REQ-1:0]          win_mask;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .pend       (pend),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_vld)
    );

    assign done = (state == WAIT) && add_ready;

    // The completing requester is no longer in flight on its completion edge,
    // so a start arriving alongside its result is accepted.
    always_comb begin
        in_flight = '0;
        win_mask  = '0;
        if (state != IDLE && !done) in_flight[grant_id] = 1'b1;
        win_mask[winner] = 1'b1;
    end

    assign accept = req_start & ~pend & ~in_flight;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_a       <= '0;
            cap_b       <= '0;
            req_overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    cap_a[i] <= req_a[i*W +: W];
                    cap_b[i] <= req_b[i*W +: W];
                end
            end
            req_overrun <= req_overrun | (req_start & ~accept);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pend       <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            grant_id   <= '0;
            add_a      <= '0;
            add_b      <= '0;
            add_start  <= 1'b0;
            busy       <= 1'b0;
            req_sum    <= '0;
            req_ready  <= '0;
        end else begin
            pend      <= pend | accept;
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_id <= winner;
                        add_a    <= cap_a[winner];
                        add_b    <= cap_b[winner];
                        pend     <= (pend | accept) & ~win_mask;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    add_start <= 1'b0;
                    if (add_ready) begin
                        req_sum             <= add_sum;
                        req_ready[grant_id] <= 1'b1;
                        last_grant          <= grant_id;
                        busy                <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: behavioural adder, round-robin reference
// model and per-scenario tasks with randomized operands.
module tb_fp_add_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_start = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [W-1:0]   req_sum;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_overrun;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_start, add_ready, busy;
    logic [1:0]     grant_id;
    logic           spur = 1'b0;

    int errors = 0;
    int checks = 0;
    int model_last = N - 1;
    logic [N-1:0] model_ovr = '0;

    always #5 clock = ~clock;

    fp_add_arbiter #(.EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(N)) dut (
        .clock(clock), .reset_n(reset_n), .req_start(req_start), .req_a(req_a), .req_b(req_b),
        .req_sum(req_sum), .req_ready(req_ready), .req_overrun(req_overrun),
        .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_sum(add_sum),
        .add_ready(add_ready), .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Adder model: fixed latency after it samples add_start.
    int          acnt = 0;
    logic        amdl_rdy = 1'b0;
    logic [W-1:0] ares = '0;
    always @(posedge clock) begin
        amdl_rdy <= 1'b0;
        if (add_start) begin
            acnt <= 4;
            ares <= fadd(add_a, add_b);
        end else if (acnt > 0) begin
            acnt <= acnt - 1;
            if (acnt == 1) amdl_rdy <= 1'b1;
        end
    end
    assign add_ready = amdl_rdy | spur;
    assign add_sum   = ares;

    logic [N-1:0] rdy_log[$];
    logic [W-1:0] sum_log[$];
    int           gnt_log[$];
    logic [W-1:0] opa_log[$];
    logic [W-1:0] opb_log[$];
    always @(negedge clock) begin
        if (add_start) begin
            gnt_log.push_back(int'(grant_id));
            opa_log.push_back(add_a);
            opb_log.push_back(add_b);
        end
        if (req_ready != '0) begin
            rdy_log.push_back(req_ready);
            sum_log.push_back(req_sum);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_rdy(input int target, input int bound, input string nm);
        int c = 0;
        while (rdy_log.size() < target && c < bound) begin
            tick(1);
            c++;
        end
        checks++;
        if (rdy_log.size() < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d ready pulses, want %0d", nm, rdy_log.size(), target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        checks++; if (req_sum !== '0) begin errors++; $display("FAIL rst_sum: got %h want 0", req_sum); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if (req_overrun !== '0) begin errors++; $display("FAIL rst_overrun: got %b want 0", req_overrun); end
        checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL rst_ops: got %h/%h want 0", add_a, add_b); end
        checks++; if (add_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctl: got start=%b busy=%b want 0", add_start, busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    endtask

    task automatic test_single();
        int r0 = rdy_log.size();
        req_a[2*W +: W] = 32'h3F80_0000;
        req_b[2*W +: W] = 32'h4000_0000;
        req_start = 4'b0100;
        tick(1);
        req_start = '0;
        tick(1);
        checks++; if (busy !== 1'b1 || add_start !== 1'b0) begin errors++; $display("FAIL single_issue: got busy=%b start=%b want 1/0", busy, add_start); end
        tick(1);
        checks++; if (add_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", add_start); end
        checks++; if (add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000 || grant_id !== 2'd2) begin
            errors++; $display("FAIL single_ops: got a=%h b=%h id=%0d want 3f800000/40000000/2", add_a, add_b, grant_id); end
        wait_rdy(r0 + 1, 30, "single");
        if (rdy_log.size() > r0) begin
            checks++; if (rdy_log[r0] !== 4'b0100 || sum_log[r0] !== 32'h4040_0000) begin
                errors++; $display("FAIL single_result: got %b/%h want 0100/40400000", rdy_log[r0], sum_log[r0]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        model_last = 2;
        tick(2);
    endtask

    task automatic test_all();
        logic [W-1:0] ta[N];
        logic [W-1:0] tb[N];
        logic [N-1:0] p = '1;
        int g0 = gnt_log.size();
        int r0 = rdy_log.size();
        int w;
        for (int i = 0; i < N; i++) begin
            ta[i] = $urandom; tb[i] = $urandom;
            req_a[i*W +: W] = ta[i]; req_b[i*W +: W] = tb[i];
        end
        req_start = '1;
        tick(1);
        req_start = '0;
        wait_rdy(r0 + N, 100, "all");
        for (int j = 0; j < N; j++) begin
            w = rr_pick(p, model_last);
            p[w] = 1'b0;
            model_last = w;
            if (rdy_log.size() > r0 + j && gnt_log.size() > g0 + j) begin
                checks++; if (gnt_log[g0+j] !== w || opa_log[g0+j] !== ta[w] || opb_log[g0+j] !== tb[w]) begin
                    errors++; $display("FAIL all_grant%0d: got id=%0d a=%h want id=%0d a=%h", j, gnt_log[g0+j], opa_log[g0+j], w, ta[w]); end
                checks++; if (rdy_log[r0+j] !== (N'(1) << w) || sum_log[r0+j] !== fadd(ta[w], tb[w])) begin
                    errors++; $display("FAIL all_ready%0d: got %b/%h want %b/%h", j, rdy_log[r0+j], sum_log[r0+j], N'(1) << w, fadd(ta[w], tb[w])); end
            end
        end
        checks++; if (gnt_log.size() - g0 !== N) begin errors++; $display("FAIL all_starts: got %0d want %0d", gnt_log.size() - g0, N); end
        checks++; if (req_overrun !== model_ovr) begin errors++; $display("FAIL all_overrun: got %b want %b", req_overrun, model_ovr); end
        tick(2);
    endtask

    task automatic test_fairness();
        logic [W-1:0] a0q[$];
        logic [W-1:0] b0q[$];
        logic [W-1:0] a1, b1, ea, eb;
        int exp_seq[$];
        logic [N-1:0] p = 4'b0011;
        int left = 3;
        int r0 = rdy_log.size();
        int w, nops, pos1;
        while (p != '0) begin
            w = rr_pick(p, model_last);
            p[w] = 1'b0;
            exp_seq.push_back(w);
            model_last = w;
            if (w == 0 && left > 0) begin p[0] = 1'b1; left--; end
        end
        nops = exp_seq.size();
        left = 3;
        a1 = $urandom; b1 = $urandom;
        ea = $urandom; eb = $urandom;
        a0q.push_back(ea); b0q.push_back(eb);
        req_a[0 +: W] = ea; req_b[0 +: W] = eb;
        req_a[W +: W] = a1; req_b[W +: W] = b1;
        req_start = 4'b0011;
        tick(1);
        req_start = '0;
        for (int c = 0; c < 300 && rdy_log.size() < r0 + nops; c++) begin
            if (req_ready[0] && left > 0) begin
                ea = $urandom; eb = $urandom;
                a0q.push_back(ea); b0q.push_back(eb);
                req_a[0 +: W] = ea; req_b[0 +: W] = eb;
                req_start[0] = 1'b1;
                left--;
            end
            tick(1);
            req_start = '0;
        end
        checks++; if (rdy_log.size() - r0 !== nops) begin errors++; $display("FAIL fair_count: got %0d want %0d", rdy_log.size() - r0, nops); end
        pos1 = -1;
        for (int j = 0; j < nops && r0 + j < rdy_log.size(); j++) begin
            if (rdy_log[r0+j] == 4'b0010) pos1 = j;
            if (exp_seq[j] == 0 && a0q.size() > 0) begin ea = a0q.pop_front(); eb = b0q.pop_front(); end
            else begin ea = a1; eb = b1; end
            checks++; if (rdy_log[r0+j] !== (N'(1) << exp_seq[j]) || sum_log[r0+j] !== fadd(ea, eb)) begin
                errors++; $display("FAIL fair_op%0d: got %b/%h want %b/%h", j, rdy_log[r0+j], sum_log[r0+j], N'(1) << exp_seq[j], fadd(ea, eb)); end
        end
        checks++; if (pos1 < 0 || pos1 > 1) begin errors++; $display("FAIL fair_req1: served at op %0d want 0 or 1", pos1); end
        tick(2);
    endtask

    task automatic test_exception();
        logic [W-1:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom;
        int r0 = rdy_log.size();
        bit sent = 1'b0;
        req_a[3*W +: W] = a1; req_b[3*W +: W] = b1;
        req_start = 4'b1000;
        tick(1);
        req_start = '0;
        for (int c = 0; c < 100 && rdy_log.size() < r0 + 2; c++) begin
            if (!sent && add_ready && grant_id == 2'd3 && busy) begin
                req_a[3*W +: W] = a2; req_b[3*W +: W] = b2;
                req_start = 4'b1000;
                sent = 1'b1;
            end
            tick(1);
            req_start = '0;
        end
        model_last = 3;
        checks++; if (rdy_log.size() - r0 !== 2) begin errors++; $display("FAIL exc_count: got %0d want 2", rdy_log.size() - r0); end
        if (rdy_log.size() >= r0 + 2) begin
            checks++; if (rdy_log[r0+1] !== 4'b1000 || sum_log[r0+1] !== fadd(a2, b2)) begin
                errors++; $display("FAIL exc_second: got %b/%h want 1000/%h", rdy_log[r0+1], sum_log[r0+1], fadd(a2, b2)); end
        end
        checks++; if (req_overrun !== model_ovr) begin errors++; $display("FAIL exc_overrun: got %b want %b", req_overrun, model_ovr); end
        tick(2);
    endtask

    task automatic test_overrun();
        logic [W-1:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom;
        int r0 = rdy_log.size();
        int g0 = gnt_log.size();
        int n1 = 0, n2 = 0;
        req_a[W +: W] = a1; req_b[W +: W] = b1;
        req_start = 4'b0010;
        tick(1);
        req_a[W +: W] = a2; req_b[W +: W] = b2;
        tick(1);
        req_start = '0;
        model_ovr[1] = 1'b1;
        wait_rdy(r0 + 1, 30, "ovr1");
        // Requester 2 restarts while its own addition is in flight.
        req_a[2*W +: W] = a2; req_b[2*W +: W] = b2;
        req_start = 4'b0100;
        tick(1);
        req_start = '0;
        for (int c = 0; c < 40 && !(add_start && grant_id == 2'd2); c++) tick(1);
        req_start = 4'b0100;
        tick(1);
        req_start = '0;
        model_ovr[2] = 1'b1;
        tick(30);
        model_last = 2;
        for (int j = r0; j < rdy_log.size(); j++) begin
            if (rdy_log[j] == 4'b0010) n1++;
            if (rdy_log[j] == 4'b0100) n2++;
        end
        checks++; if (gnt_log.size() <= g0 || opa_log[g0] !== a1 || opb_log[g0] !== b1) begin
            errors++; $display("FAIL ovr_ops: first operands not used (a=%h want %h)", gnt_log.size() > g0 ? opa_log[g0] : '0, a1); end
        checks++; if (n1 !== 1 || n2 !== 1) begin errors++; $display("FAIL ovr_pulses: got r1=%0d r2=%0d want 1/1", n1, n2); end
        checks++; if (req_overrun !== model_ovr) begin errors++; $display("FAIL ovr_sticky: got %b want %b", req_overrun, model_ovr); end
    endtask

    task automatic test_spurious();
        int r0 = rdy_log.size();
        logic [W-1:0] a = $urandom, b = $urandom;
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(2);
        checks++; if (rdy_log.size() !== r0 || busy !== 1'b0 || add_start !== 1'b0) begin
            errors++; $display("FAIL spur_idle: got ready=%0d busy=%b start=%b want 0/0/0", rdy_log.size() - r0, busy, add_start); end
        req_a[3*W +: W] = a; req_b[3*W +: W] = b;
        req_start = 4'b1000;
        tick(1);
        req_start = '0;
        tick(1);
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        checks++; if (add_start !== 1'b1 || req_ready !== '0) begin
            errors++; $display("FAIL spur_issue: got start=%b ready=%b want 1/0000", add_start, req_ready); end
        tick(1);
        checks++; if (rdy_log.size() !== r0) begin errors++; $display("FAIL spur_early: got %0d pulses want 0", rdy_log.size() - r0); end
        wait_rdy(r0 + 1, 30, "spur");
        tick(5);
        checks++; if (rdy_log.size() - r0 !== 1 || sum_log[r0] !== fadd(a, b)) begin
            errors++; $display("FAIL spur_result: got %0d pulses sum=%h want 1/%h", rdy_log.size() - r0, sum_log[r0], fadd(a, b)); end
        model_last = 3;
    endtask

    task automatic test_reset_mid();
        int r0;
        req_a[W +: W] = $urandom; req_b[W +: W] = $urandom;
        req_start = 4'b0010;
        tick(1);
        req_start = '0;
        for (int c = 0; c < 20 && !add_start; c++) tick(1);
        tick(1);
        r0 = rdy_log.size();
        #1 reset_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || add_start !== 1'b0 || grant_id !== 2'd0 || add_a !== '0 || add_b !== '0) begin
            errors++; $display("FAIL mid_ctl: got busy=%b start=%b id=%0d a=%h", busy, add_start, grant_id, add_a); end
        checks++; if (req_overrun !== '0 || req_sum !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL mid_out: got ovr=%b sum=%h rdy=%b want 0", req_overrun, req_sum, req_ready); end
        reset_n = 1'b1;
        model_last = N - 1;
        model_ovr = '0;
        tick(15);
        checks++; if (rdy_log.size() !== r0) begin errors++; $display("FAIL mid_stale: got %0d pulses want 0", rdy_log.size() - r0); end
        req_a[0 +: W] = $urandom; req_a[3*W +: W] = $urandom;
        req_start = 4'b1001;
        tick(1);
        req_start = '0;
        wait_rdy(r0 + 2, 60, "mid");
        if (rdy_log.size() >= r0 + 2) begin
            checks++; if (rdy_log[r0] !== (N'(1) << rr_pick(4'b1001, model_last)) || rdy_log[r0+1] !== 4'b1000) begin
                errors++; $display("FAIL mid_fresh: got %b,%b want 0001,1000", rdy_log[r0], rdy_log[r0+1]); end
        end
        checks++; if (req_overrun !== model_ovr) begin errors++; $display("FAIL mid_overrun: got %b want %b", req_overrun, model_ovr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all();
        test_fairness();
        test_exception();
        test_overrun();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
